unidade_controle_jogo: RTL

Moore FSM that sequences the game datapath (address/sequence counters, play register, ROM comparators). Drives zeraE/contaE/zeraS/contaS/zeraR/registraR and consumes jogadaIgualMemoria, enderecoIgualSequencia, tem_jogada and fimS. Adds a per-play inactivity timeout and reports the end status (acertou/errou/timeout) to the top level.

---
 rtl/unidade_controle_jogo_pkg.sv | 21 ++
 rtl/unidade_controle_jogo_contador_timeout.sv | 28 ++
 rtl/unidade_controle_jogo.sv | 125 ++++++++++++
 3 files changed

// File: rtl/unidade_controle_jogo_pkg.sv
// Shared state encoding for the game control unit, so the FSM and anything
// decoding db_estado agree on the same 4-bit codes.
package unidade_controle_jogo_pkg;

    localparam int unsigned LARG_ESTADO = 4;

    typedef enum logic [LARG_ESTADO-1:0] {
        INICIAL           = 4'h0,
        PREPARACAO        = 4'h1,
        INICIO_RODADA     = 4'h2,
        ESPERA_JOGADA     = 4'h3,
        REGISTRA          = 4'h4,
        COMPARA           = 4'h5,
        PROXIMA_JOGADA    = 4'h6,
        PROXIMA_SEQUENCIA = 4'h7,
        FIM_ACERTOU       = 4'hA,
        FIM_ERROU         = 4'hE,
        FIM_TIMEOUT       = 4'hF
    } estado_t;

endpackage

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// Inactivity counter: counts cycles while enabled, synchronous clear,
// flags the last allowed cycle (count == TIMEOUT_CICLOS-1).
module unidade_controle_jogo_contador_timeout #(
    parameter int unsigned TIMEOUT_CICLOS = 5000,
    parameter int unsigned LARG_TIMEOUT   = 13
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    logic [LARG_TIMEOUT-1:0] contagem;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (zera) begin
            contagem <= '0;
        end else if (conta) begin
            contagem <= contagem + LARG_TIMEOUT'(1);
        end
    end

    assign fim = conta && (contagem == LARG_TIMEOUT'(TIMEOUT_CICLOS - 1));

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore control FSM for the memory game: sequences the address/sequence
// counters and play register, and reports hit/miss/timeout end states.
module unidade_controle_jogo
    import unidade_controle_jogo_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = 5000,
    parameter int unsigned LARG_TIMEOUT   = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogadaIgualMemoria,
    input  logic       enderecoIgualSequencia,
    input  logic       tem_jogada,
    input  logic       fimS,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraS,
    output logic       contaS,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t estado, proximo;
    logic    espera;
    logic    fim_timeout;

    assign espera = (estado == ESPERA_JOGADA);

    // Counter is held at zero outside ESPERA_JOGADA, so every entry restarts it.
    unidade_controle_jogo_contador_timeout #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS),
        .LARG_TIMEOUT  (LARG_TIMEOUT)
    ) u_contador_timeout (
        .clock(clock),
        .reset(reset),
        .zera (!espera),
        .conta(espera),
        .fim  (fim_timeout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo   = INICIAL;
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraS     = 1'b0;
        contaS    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        unique case (estado)
            INICIAL: proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO: begin
                zeraE   = 1'b1;
                zeraS   = 1'b1;
                zeraR   = 1'b1;
                proximo = INICIO_RODADA;
            end
            INICIO_RODADA: begin
                zeraE   = 1'b1;
                zeraR   = 1'b1;
                proximo = ESPERA_JOGADA;
            end
            // A play arriving on the last timeout cycle takes precedence.
            ESPERA_JOGADA: begin
                if (tem_jogada)       proximo = REGISTRA;
                else if (fim_timeout) proximo = FIM_TIMEOUT;
                else                  proximo = ESPERA_JOGADA;
            end
            REGISTRA: begin
                registraR = 1'b1;
                proximo   = COMPARA;
            end
            COMPARA: begin
                if (!jogadaIgualMemoria)          proximo = FIM_ERROU;
                else if (!enderecoIgualSequencia) proximo = PROXIMA_JOGADA;
                else if (fimS)                    proximo = FIM_ACERTOU;
                else                              proximo = PROXIMA_SEQUENCIA;
            end
            PROXIMA_JOGADA: begin
                contaE  = 1'b1;
                proximo = ESPERA_JOGADA;
            end
            PROXIMA_SEQUENCIA: begin
                contaS  = 1'b1;
                proximo = INICIO_RODADA;
            end
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                proximo = iniciar ? PREPARACAO : FIM_ACERTOU;
            end
            FIM_ERROU: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                proximo = iniciar ? PREPARACAO : FIM_ERROU;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
                proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
            end
            default: proximo = INICIAL;
        endcase
    end

    assign db_estado = 4'(estado);

endmodule
